ether_rx_deframer: RTL and testbench
====================================

# ether_rx_deframer

Receive-side counterpart of the transmit path. It takes the 2-bit RMII-style dibit stream (valid plus dibit per clock), finds the Ethernet preamble and start-frame delimiter, and packs the payload dibits LSB-first into bytes. It emits one byte strobe per assembled byte and a frame-end report with byte count and error flag. It sits between the PHY dibit input and the byte-wide receive pipeline (MAC/CRC checking).

## Interface

- MIN_PREAMBLE, default 8: minimum count of consecutive 2'b01 dibits before the SFD for a frame to be accepted.
- MAX_BYTES, default 1522: maximum accepted payload bytes. LW = $clog2(MAX_BYTES+1).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- axiiv  in  1  input dibit valid (carrier/data valid).
- axiid  in  2  input dibit; the first dibit of each byte carries bits [1:0].
- axiov  out  1  one-cycle strobe: axiod holds a complete byte.
- axiod  out  8  assembled byte; holds its last value when axiov is low.
- frame_done  out  1  one-cycle pulse at end of each frame that reached DATA.
- frame_err  out  1  valid only with frame_done: frame was malformed.
- frame_len  out  LW  valid with frame_done: bytes emitted in the frame, saturating at MAX_BYTES.

## Operation

FSM states: IDLE, PREAMBLE, DATA, DROP.

- **IDLE**
  - axiiv=1 and axiid=01: go to PREAMBLE, with pre_cnt=1.
  - axiiv=1 with any other dibit: go to DROP.
- **PREAMBLE**
  - axiiv=0: go to IDLE silently.
  - axiid=01: pre_cnt++, saturating at MIN_PREAMBLE.
  - axiid=11: if pre_cnt ≥ MIN_PREAMBLE, go to DATA with dibit_cnt=0 and byte_cnt=0; otherwise go to DROP.
  - axiid=00 or 10: go to DROP.
- **DATA**
  - Each valid dibit is written to shift bits [2k+1:2k], where k = dibit_cnt (0..3).
  - On k=3, the byte is complete: output it, byte_cnt++ (saturating), dibit_cnt wraps to 0.
  - Bytes beyond MAX_BYTES are still output but set a sticky overflow flag.
  - axiiv=0 ends the frame and goes to IDLE. Report frame_err = (dibit_cnt≠0) | (byte_cnt==0) | overflow; frame_len = byte_cnt.
  - A partial byte is discarded, never output.
- **DROP**
  - No outputs. Stay until axiiv=0, then go to IDLE.
- Invalid dibits (axiiv=0) inside DATA always terminate the frame; there are no gaps within a frame.
- Preamble or SFD failure never produces frame_done.

## Timing

- Reset (async assert, synchronous release):
  - State goes to IDLE; all counters and the overflow flag clear.
  - axiov=0, axiod=8'h00, frame_done=0, frame_err=0, frame_len=0.
- All outputs are registered.
- Byte latency: axiov rises in the cycle after the clock edge that samples the 4th dibit of a byte. Bytes therefore arrive at most 1 per 4 cycles.
- SFD dibit (11): its sampling edge moves the FSM to DATA. The next valid dibit is bit[1:0] of byte 0.
- frame_done, frame_err, and frame_len are asserted for exactly one cycle, in the cycle after the edge that samples axiiv=0 in DATA.
- The last byte's axiov always precedes frame_done by ≥1 cycle; they never coincide.
- Back-to-back frames: the FSM is in IDLE on the same edge that samples axiiv=0. A new 01 on the very next cycle starts PREAMBLE. A one-cycle gap is sufficient.
- Reset mid-frame: the partial byte and counts are discarded; no frame_done is generated for the aborted frame. After release, mid-frame dibits (not 01) go to DROP until axiiv falls.
- pre_cnt saturation means long preambles (31 dibits of 01 as on the wire) are accepted.

## Test plan

- **Nominal frame.** Stimulus: 31×01, then 11, then bytes 0xA5 (dibits 01,01,10,10) and 0x3C (00,11,11,00), then axiiv=0. Required: axiov pulses with axiod=A5, then 3C, 4 cycles apart; frame_done with frame_len=2 and frame_err=0.
- **Short preamble.** Stimulus: 4×01 then 11 (MIN_PREAMBLE=8), then 8 dibits. Required: no axiov and no frame_done; FSM in DROP until axiiv=0.
- **Trailing partial byte.** Stimulus: valid preamble+SFD, byte 0x55, then 2 extra dibits, then axiiv=0. Required: one axiov with 0x55; frame_done with frame_len=1 and frame_err=1.
- **Bad preamble dibit.** Stimulus: 10×01, then 10, then 11, then data. Required: no outputs until axiiv low; the next good frame decodes correctly.
- **Reset mid-DATA.** Stimulus: assert rst 2 cycles after byte 0 with axiiv held high; release; keep dibits 10; then drop axiiv and send a nominal frame. Required: outputs 0 during reset; no frame_done for the aborted frame; the second frame decodes as in the nominal case.
- **Back-to-back frames.** Stimulus: two nominal 22-byte frames (all bytes 0x55) separated by one cycle of axiiv=0. Required: 44 axiov strobes; two frame_done pulses, each with frame_len=22 and frame_err=0.

Source files
------------

// File: rtl/ether_rx_deframer_if.sv
// ether_rx_deframer_if: dibit input and byte/frame-report output bundle of the RMII receive deframer.
interface ether_rx_deframer_if #(
    parameter int MAX_BYTES = 1522
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    logic          axiiv;
    logic [1:0]    axiid;
    logic          axiov;
    logic [7:0]    axiod;
    logic          frame_done;
    logic          frame_err;
    logic [LW-1:0] frame_len;
    modport master (output axiiv, axiid, input axiov, axiod, frame_done, frame_err, frame_len);
    modport slave (input axiiv, axiid, output axiov, axiod, frame_done, frame_err, frame_len);
endinterface

// File: rtl/ether_rx_deframer.sv
// ether_rx_deframer: finds preamble/SFD in an RMII dibit stream, packs payload LSB-first into bytes, reports frame end.
module ether_rx_deframer #(
    parameter int MIN_PREAMBLE = 8,
    parameter int MAX_BYTES    = 1522
) (
    input logic                clk,
    input logic                rst,
    ether_rx_deframer_if.slave rx_if
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int PW = $clog2(MIN_PREAMBLE + 1);
    localparam logic [PW-1:0] PRE_MIN  = PW'(MIN_PREAMBLE);
    localparam logic [LW-1:0] BYTE_MAX = LW'(MAX_BYTES);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]    dibit_cnt_q, dibit_cnt_d;
    logic [LW-1:0] byte_cnt_q, byte_cnt_d, len_q, len_d;
    logic [5:0]    shift_q, shift_d;
    logic [7:0]    axiod_q, axiod_d;
    logic          ovf_q, ovf_d, axiov_q, axiov_d, done_q, done_d, err_q, err_d;
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        dibit_cnt_d = dibit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        ovf_d       = ovf_q;
        axiov_d     = 1'b0;
        axiod_d     = axiod_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        len_d       = len_q;
        case (state_q)
            IDLE: if (rx_if.axiiv) begin
                state_d   = rx_if.axiid == 2'b01 ? PREAMBLE : DROP;
                pre_cnt_d = PW'(1);
            end
            PREAMBLE: if (!rx_if.axiiv) state_d = IDLE;
            else if (rx_if.axiid == 2'b01) pre_cnt_d = pre_cnt_q == PRE_MIN ? pre_cnt_q : pre_cnt_q + 1'b1;
            else if (rx_if.axiid == 2'b11 && pre_cnt_q >= PRE_MIN) begin
                state_d     = DATA;
                dibit_cnt_d = '0;
                byte_cnt_d  = '0;
                ovf_d       = 1'b0;
            end else state_d = DROP;
            DATA: if (!rx_if.axiiv) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = (dibit_cnt_q != '0) | (byte_cnt_q == '0) | ovf_q;
                len_d   = byte_cnt_q;
            end else begin
                // New dibits enter at the top, so after three dibits shift_q holds bits [5:0] in order
                shift_d     = {rx_if.axiid, shift_q[5:2]};
                dibit_cnt_d = dibit_cnt_q + 1'b1;
                if (dibit_cnt_q == 2'd3) begin
                    axiov_d    = 1'b1;
                    axiod_d    = {rx_if.axiid, shift_q};
                    byte_cnt_d = byte_cnt_q == BYTE_MAX ? byte_cnt_q : byte_cnt_q + 1'b1;
                    ovf_d      = ovf_q | (byte_cnt_q == BYTE_MAX);
                end
            end
            default: if (!rx_if.axiiv) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            dibit_cnt_q <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            ovf_q       <= 1'b0;
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            dibit_cnt_q <= dibit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            ovf_q       <= ovf_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
            done_q      <= done_d;
            err_q       <= err_d;
            len_q       <= len_d;
        end
    end
    assign rx_if.axiov      = axiov_q;
    assign rx_if.axiod      = axiod_q;
    assign rx_if.frame_done = done_q;
    assign rx_if.frame_err  = err_q;
    assign rx_if.frame_len  = len_q;
endmodule

// File: tb/tb_ether_rx_deframer.sv
// tb_ether_rx_deframer: directed dibit frames against hand-computed bytes and frame reports.
module tb_ether_rx_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0, n_fail = 0, cyc = 0, coinc = 0, last_t = 0;
    logic [7:0] bq[$];
    int   bt[$], dl[$], de[$], dl2[$], de2[$];
    ether_rx_deframer_if bus();
    ether_rx_deframer_if #(.MAX_BYTES(4)) bus2();
    assign bus2.axiiv = bus.axiiv;
    assign bus2.axiid = bus.axiid;
    ether_rx_deframer dut (.clk(clk), .rst(rst), .rx_if(bus.slave));
    ether_rx_deframer #(.MAX_BYTES(4)) dut2 (.clk(clk), .rst(rst), .rx_if(bus2.slave));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        cyc++;
        if (bus.axiov) begin
            bq.push_back(bus.axiod);
            bt.push_back(cyc);
        end
        if (bus.frame_done) begin
            dl.push_back(int'(bus.frame_len));
            de.push_back(int'(bus.frame_err));
        end
        if (bus2.frame_done) begin
            dl2.push_back(int'(bus2.frame_len));
            de2.push_back(int'(bus2.frame_err));
        end
        if (bus.axiov && bus.frame_done) coinc++;
    end
    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        bus.axiiv = v;
        bus.axiid = d;
    endtask
    task automatic pre(input int n);
        repeat (n) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
    endtask
    task automatic sbyte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2]);
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask
    task automatic clr();
        bq.delete(); bt.delete(); dl.delete(); de.delete(); dl2.delete(); de2.delete();
    endtask
    function automatic int popb();
        if (bq.size() == 0) return -1;
        last_t = bt.pop_front();
        return int'(bq.pop_front());
    endfunction
    task automatic chk_frames(input string tag, input int nd, input int len, input int err);
        chk({tag, " done_count"}, dl.size(), nd);
        for (int i = 0; i < dl.size() && i < nd; i++) begin
            chk({tag, " frame_len"}, dl[i], len);
            chk({tag, " frame_err"}, de[i], err);
        end
    endtask
    initial begin
        int t0, bad;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset axiov", bus.axiov, 0);
        chk("reset axiod", bus.axiod, 0);
        chk("reset frame_done", bus.frame_done, 0);
        chk("reset frame_err", bus.frame_err, 0);
        chk("reset frame_len", bus.frame_len, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        // nominal: 31x01, SFD, A5, 3C
        clr();
        pre(31); sbyte(8'hA5); sbyte(8'h3C); idle(3);
        chk("nominal n_bytes", bq.size(), 2);
        chk("nominal byte0", popb(), 'hA5);
        t0 = last_t;
        chk("nominal byte1", popb(), 'h3C);
        chk("nominal spacing", last_t - t0, 4);
        chk_frames("nominal", 1, 2, 0);
        // short preamble
        clr();
        pre(4); repeat (8) drive(1'b1, 2'b10); idle(3);
        chk("short n_bytes", bq.size(), 0);
        chk("short done_count", dl.size(), 0);
        // trailing partial byte, preamble exactly MIN_PREAMBLE
        clr();
        pre(8); sbyte(8'h55); drive(1'b1, 2'b01); drive(1'b1, 2'b01); idle(3);
        chk("partial n_bytes", bq.size(), 1);
        chk("partial byte0", popb(), 'h55);
        chk_frames("partial", 1, 1, 1);
        // empty frame
        clr();
        pre(8); idle(3);
        chk("empty n_bytes", bq.size(), 0);
        chk_frames("empty", 1, 0, 1);
        // bad preamble dibit then good frame
        clr();
        repeat (10) drive(1'b1, 2'b01);
        drive(1'b1, 2'b10); drive(1'b1, 2'b11); sbyte(8'hA5); idle(1);
        chk("badpre n_bytes", bq.size(), 0);
        chk("badpre done_count", dl.size(), 0);
        pre(31); sbyte(8'hA5); sbyte(8'h3C); idle(3);
        chk("badpre next n_bytes", bq.size(), 2);
        chk("badpre next byte0", popb(), 'hA5);
        chk("badpre next byte1", popb(), 'h3C);
        chk_frames("badpre next", 1, 2, 0);
        // reset mid-DATA
        clr();
        pre(31); sbyte(8'hA5); drive(1'b1, 2'b10); drive(1'b1, 2'b10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst axiov", bus.axiov, 0);
        chk("midrst axiod", bus.axiod, 0);
        chk("midrst frame_done", bus.frame_done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) drive(1'b1, 2'b10);
        idle(1);
        pre(31); sbyte(8'hA5); sbyte(8'h3C); idle(3);
        chk("midrst n_bytes", bq.size(), 3);
        chk("midrst byte pre", popb(), 'hA5);
        chk("midrst byte0", popb(), 'hA5);
        chk("midrst byte1", popb(), 'h3C);
        chk_frames("midrst", 1, 2, 0);
        // overflow against the MAX_BYTES=4 instance
        clr();
        pre(8); repeat (5) sbyte(8'h11); idle(3);
        chk("ovf n_bytes", bq.size(), 5);
        chk_frames("ovf big", 1, 5, 0);
        chk("ovf small done_count", dl2.size(), 1);
        chk("ovf small frame_len", dl2.size() > 0 ? dl2[0] : -1, 4);
        chk("ovf small frame_err", de2.size() > 0 ? de2[0] : -1, 1);
        clr();
        pre(8); repeat (4) sbyte(8'h22); idle(3);
        chk("atmax small done_count", dl2.size(), 1);
        chk("atmax small frame_len", dl2.size() > 0 ? dl2[0] : -1, 4);
        chk("atmax small frame_err", de2.size() > 0 ? de2[0] : -1, 0);
        // back-to-back 22-byte frames with a one-cycle gap
        clr();
        pre(31); repeat (22) sbyte(8'h55); idle(1);
        pre(31); repeat (22) sbyte(8'h55); idle(3);
        chk("b2b n_bytes", bq.size(), 44);
        bad = 0;
        foreach (bq[i]) if (bq[i] !== 8'h55) bad++;
        chk("b2b bad_bytes", bad, 0);
        chk_frames("b2b", 2, 22, 0);
        chk("axiov/frame_done overlap", coinc, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
